// File: rtl/group_event_arbiter.sv
// rtl/group_event_arbiter.sv - arbitrates per-group pixel events onto one output stream
// Selection happens in IDLE or on the OUT handshake; the winner's data is captured on the GRANT edge.
module group_event_arbiter #(
  parameter int GRP_ROWS = 4,
  parameter int GRP_COLS = 4,
  parameter int GRP_DIM  = 4,
  parameter int TS_W     = 32,
  parameter int RR_MODE  = 1,
  localparam int NG = GRP_ROWS * GRP_COLS,
  localparam int LW = $clog2(GRP_DIM),
  localparam int XW = $clog2(GRP_COLS * GRP_DIM),
  localparam int YW = $clog2(GRP_ROWS * GRP_DIM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NG-1:0]      grp_req,
  input  logic [NG*LW-1:0]   grp_x,
  input  logic [NG*LW-1:0]   grp_y,
  input  logic [NG*TS_W-1:0] grp_ts,
  input  logic [NG-1:0]      grp_pol,
  output logic [NG-1:0]      grp_gnt,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic [XW-1:0]      ev_x,
  output logic [YW-1:0]      ev_y,
  output logic [TS_W-1:0]    ev_ts,
  output logic               ev_pol,
  output logic [15:0]        ev_count
);

  localparam int IW = (NG > 1) ? $clog2(NG) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_OUT   = 2'd2;

  logic [1:0]      state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   ptr_nxt;
  logic            sel_any;
  logic            take;
  logic [LW-1:0]   wx;
  logic [LW-1:0]   wy;
  logic [TS_W-1:0] wts;
  logic            wpol;
  logic [XW-1:0]   gx;
  logic [YW-1:0]   gy;

  // First requester at or after the search base, wrapping; base is 0 in fixed-priority mode.
  always_comb begin
    int j;
    sel     = '0;
    sel_any = 1'b0;
    j       = 0;
    for (int i = 0; i < NG; i++) begin
      j = (RR_MODE != 0) ? int'(ptr) + i : i;
      if (j >= NG) j = j - NG;
      if (!sel_any && grp_req[j[IW-1:0]]) begin
        sel_any = 1'b1;
        sel     = j[IW-1:0];
      end
    end
  end

  assign ptr_nxt = (int'(sel) == NG - 1) ? '0 : sel + 1'b1;
  assign take    = sel_any && ((state == S_IDLE) || ((state == S_OUT) && ev_ready));

  always_comb begin
    wx   = grp_x[int'(win)*LW +: LW];
    wy   = grp_y[int'(win)*LW +: LW];
    wts  = grp_ts[int'(win)*TS_W +: TS_W];
    wpol = grp_pol[win];
    gx   = XW'((int'(win) % GRP_COLS) * GRP_DIM + int'(wx));
    gy   = YW'((int'(win) / GRP_COLS) * GRP_DIM + int'(wy));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      win      <= '0;
      grp_gnt  <= '0;
      ev_valid <= 1'b0;
      ev_x     <= '0;
      ev_y     <= '0;
      ev_ts    <= '0;
      ev_pol   <= 1'b0;
      ev_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take) state <= S_GRANT;
        end
        S_GRANT: begin
          grp_gnt  <= '0;
          ev_x     <= gx;
          ev_y     <= gy;
          ev_ts    <= wts;
          ev_pol   <= wpol;
          ev_valid <= 1'b1;
          state    <= S_OUT;
        end
        S_OUT: begin
          if (ev_ready) begin
            ev_count <= ev_count + 16'd1;
            ev_valid <= 1'b0;
            state    <= take ? S_GRANT : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (take) begin
        win     <= sel;
        grp_gnt <= NG'(1) << sel;
        if (RR_MODE != 0) ptr <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_group_event_arbiter.sv
// tb/tb_group_event_arbiter.sv - directed bench for group_event_arbiter
// Runs a round-robin and a fixed-priority instance side by side on the same stimulus.
module tb_group_event_arbiter;

  localparam int NG = 16;
  localparam int LW = 2;
  localparam int TW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NG-1:0]   grp_req = '0;
  logic [NG*LW-1:0] grp_x = '0;
  logic [NG*LW-1:0] grp_y = '0;
  logic [NG*TW-1:0] grp_ts = '0;
  logic [NG-1:0]   grp_pol = '0;
  logic            ev_ready = 1'b1;

  logic [NG-1:0] gnt_r, gnt_f;
  logic          val_r, val_f;
  logic [3:0]    x_r, x_f, y_r, y_f;
  logic [TW-1:0] ts_r, ts_f;
  logic          pol_r, pol_f;
  logic [15:0]   cnt_r, cnt_f;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_cnt = 0;

  always #5 clk = ~clk;

  group_event_arbiter #(.RR_MODE(1)) dut (
    .clk(clk), .rst(rst), .grp_req(grp_req), .grp_x(grp_x), .grp_y(grp_y),
    .grp_ts(grp_ts), .grp_pol(grp_pol), .grp_gnt(gnt_r), .ev_valid(val_r),
    .ev_ready(ev_ready), .ev_x(x_r), .ev_y(y_r), .ev_ts(ts_r), .ev_pol(pol_r),
    .ev_count(cnt_r)
  );

  group_event_arbiter #(.RR_MODE(0)) dut_fix (
    .clk(clk), .rst(rst), .grp_req(grp_req), .grp_x(grp_x), .grp_y(grp_y),
    .grp_ts(grp_ts), .grp_pol(grp_pol), .grp_gnt(gnt_f), .ev_valid(val_f),
    .ev_ready(ev_ready), .ev_x(x_f), .ev_y(y_f), .ev_ts(ts_f), .ev_pol(pol_f),
    .ev_count(cnt_f)
  );

  typedef struct {
    int          g;
    logic [15:0] gnt;
    logic [1:0]  lx;
    logic [1:0]  ly;
    logic [31:0] ts;
    logic        pol;
    logic [3:0]  ex;
    logic [3:0]  ey;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_group(input int g, input logic [1:0] lx, input logic [1:0] ly,
                            input logic [31:0] ts, input logic pol);
    grp_x[g*LW +: LW]  = lx;
    grp_y[g*LW +: LW]  = ly;
    grp_ts[g*TW +: TW] = ts;
    grp_pol[g]         = pol;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    grp_req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  initial begin
    logic [3:0]  hold_x;
    logic [31:0] hold_ts;
    logic [15:0] rr_seq [4];

    vecs[0] = '{0,  16'h0001, 2'd0, 2'd0, 32'h0000_0001, 1'b0, 4'd0,  4'd0};
    vecs[1] = '{5,  16'h0020, 2'd2, 2'd3, 32'h0000_1234, 1'b1, 4'd6,  4'd7};
    vecs[2] = '{15, 16'h8000, 2'd3, 2'd3, 32'hDEAD_BEEF, 1'b1, 4'd15, 4'd15};
    vecs[3] = '{3,  16'h0008, 2'd1, 2'd2, 32'h0BAD_F00D, 1'b0, 4'd13, 4'd2};
    vecs[4] = '{12, 16'h1000, 2'd2, 2'd1, 32'h5555_AAAA, 1'b1, 4'd2,  4'd13};
    vecs[5] = '{9,  16'h0200, 2'd0, 2'd3, 32'h0000_0099, 1'b0, 4'd4,  4'd11};
    rr_seq = '{16'h0001, 16'h8000, 16'h0001, 16'h8000};

    do_reset();
    check("rst_gnt",   64'(gnt_r), 64'h0);
    check("rst_valid", 64'(val_r), 64'h0);
    check("rst_x",     64'(x_r),   64'h0);
    check("rst_y",     64'(y_r),   64'h0);
    check("rst_ts",    64'(ts_r),  64'h0);
    check("rst_pol",   64'(pol_r), 64'h0);
    check("rst_cnt",   64'(cnt_r), 64'h0);

    // Single requests: background data in all groups, target group overwritten.
    for (int v = 0; v < 6; v++) begin
      for (int g = 0; g < NG; g++) load_group(g, 2'(g + 1), 2'(g + 2), 32'hFFFF_0000 | g, 1'(~g));
      load_group(vecs[v].g, vecs[v].lx, vecs[v].ly, vecs[v].ts, vecs[v].pol);
      grp_req  = vecs[v].gnt;
      ev_ready = 1'b1;
      @(negedge clk);
      check($sformatf("v%0d_gnt", v), 64'(gnt_r), 64'(vecs[v].gnt));
      check($sformatf("v%0d_valid_lo", v), 64'(val_r), 64'h0);
      grp_req = '0;
      @(negedge clk);
      check($sformatf("v%0d_gnt_off", v), 64'(gnt_r), 64'h0);
      check($sformatf("v%0d_valid", v), 64'(val_r), 64'h1);
      check($sformatf("v%0d_x", v), 64'(x_r), 64'(vecs[v].ex));
      check($sformatf("v%0d_y", v), 64'(y_r), 64'(vecs[v].ey));
      check($sformatf("v%0d_ts", v), 64'(ts_r), 64'(vecs[v].ts));
      check($sformatf("v%0d_pol", v), 64'(pol_r), 64'(vecs[v].pol));
      exp_cnt++;
      @(negedge clk);
      check($sformatf("v%0d_valid_end", v), 64'(val_r), 64'h0);
      check($sformatf("v%0d_cnt", v), 64'(cnt_r), 64'(exp_cnt));
    end

    // Round-robin fairness vs fixed priority, both from a fresh pointer.
    do_reset();
    load_group(0, 2'd1, 2'd2, 32'h0000_00A0, 1'b0);
    load_group(15, 2'd3, 2'd0, 32'h0000_00F0, 1'b1);
    grp_req = 16'h8001;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k % 2 == 1) begin
        check($sformatf("rr_gnt%0d", k / 2), 64'(gnt_r), 64'(rr_seq[k / 2]));
        check($sformatf("fix_gnt%0d", k / 2), 64'(gnt_f), 64'h0001);
        check($sformatf("rr_vlo%0d", k / 2), 64'(val_r), 64'h0);
      end else begin
        check($sformatf("rr_val%0d", k / 2), 64'(val_r), 64'h1);
        check($sformatf("rr_x%0d", k / 2), 64'(x_r), (rr_seq[k / 2 - 1] == 16'h0001) ? 64'd1 : 64'd15);
        check($sformatf("fix_x%0d", k / 2), 64'(x_f), 64'd1);
        check($sformatf("fix_y%0d", k / 2), 64'(y_f), 64'd2);
        exp_cnt++;
      end
    end
    grp_req = '0;
    @(negedge clk);
    check("rr_cnt", 64'(cnt_r), 64'(exp_cnt));
    check("fix_cnt", 64'(cnt_f), 64'(exp_cnt));

    // Backpressure: event held, other requests ignored while stalled.
    load_group(5, 2'd2, 2'd3, 32'h0000_1234, 1'b1);
    ev_ready = 1'b0;
    grp_req  = 16'h0020;
    @(negedge clk);
    check("bp_gnt", 64'(gnt_r), 64'h0020);
    grp_req = 16'hFFFF;
    @(negedge clk);
    hold_x  = x_r;
    hold_ts = ts_r;
    check("bp_x", 64'(x_r), 64'd6);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_valid%0d", k), 64'(val_r), 64'h1);
      check($sformatf("bp_xhold%0d", k), 64'(x_r), 64'(hold_x));
      check($sformatf("bp_tshold%0d", k), 64'(ts_r), 64'(hold_ts));
      check($sformatf("bp_nognt%0d", k), 64'(gnt_r), 64'h0);
      check($sformatf("bp_cnt%0d", k), 64'(cnt_r), 64'(exp_cnt));
      @(negedge clk);
    end
    ev_ready = 1'b1;
    grp_req  = '0;
    exp_cnt++;
    @(negedge clk);
    check("bp_valid_end", 64'(val_r), 64'h0);
    check("bp_cnt_end", 64'(cnt_r), 64'(exp_cnt));
    @(negedge clk);
    check("bp_idle_gnt", 64'(gnt_r), 64'h0);

    // Reset while an event is pending in OUT.
    ev_ready = 1'b0;
    grp_req  = 16'h0008;
    @(negedge clk);
    grp_req = '0;
    @(negedge clk);
    check("mr_valid_pre", 64'(val_r), 64'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    check("mr_valid", 64'(val_r), 64'h0);
    check("mr_cnt", 64'(cnt_r), 64'h0);
    check("mr_gnt", 64'(gnt_r), 64'h0);
    grp_req  = 16'h8001;
    ev_ready = 1'b1;
    @(negedge clk);
    check("mr_ptr_gnt", 64'(gnt_r), 64'h0001);
    grp_req = '0;
    @(negedge clk);
    check("mr_valid_new", 64'(val_r), 64'h1);
    check("mr_x_new", 64'(x_r), 64'd1);
    exp_cnt++;
    @(negedge clk);
    check("mr_cnt_new", 64'(cnt_r), 64'(exp_cnt));

    // Counter wrap: preload near the top, then two handshakes cross 0xFFFF.
    force dut.ev_count = 16'hFFFE;
    @(negedge clk);
    release dut.ev_count;
    @(negedge clk);
    check("wrap_pre", 64'(cnt_r), 64'hFFFE);
    for (int k = 0; k < 2; k++) begin
      grp_req = 16'h0400;
      @(negedge clk);
      grp_req = '0;
      @(negedge clk);
      @(negedge clk);
    end
    check("wrap_cnt", 64'(cnt_r), 64'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
